// File: rtl/class_router_fifo.sv
// Per-class FIFO router with a single registered output port.
// Strict-priority or round-robin drain, flow-control flags upstream.
module class_router_fifo #(
  parameter int DATA_SIZE   = 10,
  parameter int CLASS_BITS  = 1,
  parameter int NUM_CLASSES = 2,
  parameter int DEPTH       = 4,
  parameter int AF_THRESH   = 3,
  parameter int AE_THRESH   = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_SIZE-1:0]   in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_SIZE-1:0]   out_data,
  output logic [CLASS_BITS-1:0]  out_class,
  output logic [NUM_CLASSES-1:0] fifo_empty,
  output logic [NUM_CLASSES-1:0] fifo_full,
  output logic [NUM_CLASSES-1:0] almost_full,
  output logic [NUM_CLASSES-1:0] almost_empty,
  output logic [NUM_CLASSES-1:0] fifo_error,
  output logic                   pause
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_SIZE-1:0]  mem    [NUM_CLASSES][DEPTH];
  logic [AW-1:0]         wr_ptr [NUM_CLASSES];
  logic [AW-1:0]         rd_ptr [NUM_CLASSES];
  logic [CW-1:0]         count  [NUM_CLASSES];
  logic [CLASS_BITS-1:0] in_cls;
  logic [CLASS_BITS-1:0] grant;
  logic [CLASS_BITS-1:0] idx;
  logic [CLASS_BITS-1:0] rr_ptr;
  logic                  any_ne;
  logic                  load;
  logic [NUM_CLASSES-1:0] hit;
  logic [NUM_CLASSES-1:0] push;
  logic [NUM_CLASSES-1:0] pop;

  assign in_cls = in_data[DATA_SIZE-1 -: CLASS_BITS];
  assign load   = out_ready || !out_valid;

  // Status flags decoded from the registered counts
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      fifo_empty[c]   = (count[c] == '0);
      fifo_full[c]    = (count[c] == CW'(DEPTH));
      almost_full[c]  = (count[c] >= CW'(AF_THRESH));
      almost_empty[c] = (count[c] <= CW'(AE_THRESH));
    end
    pause  = |almost_full;
    any_ne = ~&fifo_empty;
  end

  // Arbiter: highest index, or first non-empty from rr_ptr
  always_comb begin
    grant = '0;
    idx   = '0;
    if (ARB_MODE == 0) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        if (!fifo_empty[c]) grant = CLASS_BITS'(c);
    end else begin
      for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
        idx = rr_ptr + CLASS_BITS'(i);
        if (!fifo_empty[idx]) grant = idx;
      end
    end
  end

  // Push/pop decisions; a full FIFO being popped still takes the push
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      hit[c]  = in_valid && (in_cls == CLASS_BITS'(c));
      pop[c]  = load && any_ne && (grant == CLASS_BITS'(c));
      push[c] = hit[c] && (!fifo_full[c] || pop[c]);
    end
  end

  // Pointers, occupancy and sticky overflow per class
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        wr_ptr[c]     <= '0;
        rd_ptr[c]     <= '0;
        count[c]      <= '0;
        fifo_error[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + AW'(1);
        if (push[c] && !pop[c])
          count[c] <= count[c] + CW'(1);
        else if (pop[c] && !push[c])
          count[c] <= count[c] - CW'(1);
        if (hit[c] && fifo_full[c] && !pop[c])
          fifo_error[c] <= 1'b1;
      end
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CLASSES; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= in_data;
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_class <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (any_ne) begin
        out_valid <= 1'b1;
        out_data  <= mem[grant][rd_ptr[grant]];
        out_class <= grant;
        if (ARB_MODE != 0) rr_ptr <= grant + CLASS_BITS'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_class_router_fifo.sv
// Directed bench for class_router_fifo.
// One strict-priority and one round-robin instance share stimulus.
module tb_class_router_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       out_ready = 1'b0;

  logic       o0_valid, o1_valid;
  logic [9:0] o0_data, o1_data;
  logic       o0_class, o1_class;
  logic [1:0] o0_empty, o0_full, o0_af, o0_ae, o0_err;
  logic [1:0] o1_empty, o1_full, o1_af, o1_ae, o1_err;
  logic       o0_pause, o1_pause;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  class_router_fifo #(.ARB_MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready),
    .out_valid(o0_valid), .out_data(o0_data),
    .out_class(o0_class), .fifo_empty(o0_empty),
    .fifo_full(o0_full), .almost_full(o0_af),
    .almost_empty(o0_ae), .fifo_error(o0_err),
    .pause(o0_pause)
  );

  class_router_fifo #(.ARB_MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready),
    .out_valid(o1_valid), .out_data(o1_data),
    .out_class(o1_class), .fifo_empty(o1_empty),
    .fifo_full(o1_full), .almost_full(o1_af),
    .almost_empty(o1_ae), .fifo_error(o1_err),
    .pause(o1_pause)
  );

  typedef struct {
    logic [9:0] din;
    logic [1:0] empty;
    logic [1:0] ae;
    logic [1:0] af;
    logic [1:0] full;
    logic [1:0] err;
    logic       pause;
    logic       ov;
  } vec_t;

  vec_t tv [6];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic write(input logic [9:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect0(input string name, input logic [9:0] d,
                         input logic c);
    check({name, "_v"}, 32'(o0_valid), 32'd1);
    check({name, "_d"}, 32'(o0_data), 32'(d));
    check({name, "_c"}, 32'(o0_class), 32'(c));
    step();
  endtask

  task automatic expect1(input string name, input logic [9:0] d,
                         input logic c);
    check({name, "_v"}, 32'(o1_valid), 32'd1);
    check({name, "_d"}, 32'(o1_data), 32'(d));
    check({name, "_c"}, 32'(o1_class), 32'(c));
    step();
  endtask

  logic [9:0] e0 [4];
  logic [9:0] e1 [4];
  int got0, got1, sent, cyc;

  initial begin
    tv[0] = '{10'h3FF, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tv[1] = '{10'h3FF, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
    tv[2] = '{10'h3FF, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
    tv[3] = '{10'h3FF, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1};
    tv[4] = '{10'h3FF, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1};
    tv[5] = '{10'h3FF, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1};

    // reset values
    do_reset();
    check("rst_valid", 32'(o0_valid), 32'd0);
    check("rst_data", 32'(o0_data), 32'd0);
    check("rst_class", 32'(o0_class), 32'd0);
    check("rst_empty", 32'(o0_empty), 32'h3);
    check("rst_ae", 32'(o0_ae), 32'h3);
    check("rst_full", 32'(o0_full), 32'd0);
    check("rst_af", 32'(o0_af), 32'd0);
    check("rst_err", 32'(o0_err), 32'd0);
    check("rst_pause", 32'(o0_pause), 32'd0);

    // fill class 1 with the sink stalled; one word sits in the
    // output register so the FIFO overflows on the 6th write
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = tv[i].din;
      step();
      check($sformatf("fill%0d_empty", i), 32'(o0_empty), 32'(tv[i].empty));
      check($sformatf("fill%0d_ae", i), 32'(o0_ae), 32'(tv[i].ae));
      check($sformatf("fill%0d_af", i), 32'(o0_af), 32'(tv[i].af));
      check($sformatf("fill%0d_full", i), 32'(o0_full), 32'(tv[i].full));
      check($sformatf("fill%0d_err", i), 32'(o0_err), 32'(tv[i].err));
      check($sformatf("fill%0d_pause", i), 32'(o0_pause), 32'(tv[i].pause));
      check($sformatf("fill%0d_ov", i), 32'(o0_valid), 32'(tv[i].ov));
    end
    in_valid = 1'b0;
    check("fill_hold_d", 32'(o0_data), 32'h3FF);
    check("fill_hold_c", 32'(o0_class), 32'd1);

    // strict priority: class 1 overtakes earlier class 0 words
    do_reset();
    write(10'h001);
    write(10'h155);
    write(10'h156);
    write(10'h3FF);
    out_ready = 1'b1;
    expect0("sp0", 10'h001, 1'b0);
    expect0("sp1", 10'h3FF, 1'b1);
    expect0("sp2", 10'h155, 1'b0);
    expect0("sp3", 10'h156, 1'b0);
    check("sp_idle", 32'(o0_valid), 32'd0);
    check("sp_empty", 32'(o0_empty), 32'h3);

    // round-robin on the second instance
    do_reset();
    write(10'h200);
    write(10'h010);
    write(10'h011);
    write(10'h012);
    write(10'h210);
    write(10'h211);
    write(10'h212);
    out_ready = 1'b1;
    expect1("rr0", 10'h200, 1'b1);
    expect1("rr1", 10'h010, 1'b0);
    expect1("rr2", 10'h210, 1'b1);
    expect1("rr3", 10'h011, 1'b0);
    expect1("rr4", 10'h211, 1'b1);
    expect1("rr5", 10'h012, 1'b0);
    expect1("rr6", 10'h212, 1'b1);
    check("rr_idle", 32'(o1_valid), 32'd0);

    // asynchronous reset with both FIFOs loaded and error set
    do_reset();
    for (int i = 0; i < 6; i++) write(10'h3FF);
    write(10'h001);
    write(10'h001);
    check("mid_pre_err", 32'(o0_err), 32'h2);
    check("mid_pre_empty", 32'(o0_empty), 32'h0);
    #2 reset = 1'b0;
    #1;
    check("mid_valid", 32'(o0_valid), 32'd0);
    check("mid_err", 32'(o0_err), 32'd0);
    check("mid_empty", 32'(o0_empty), 32'h3);
    check("mid_pause", 32'(o0_pause), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_post%0d_v", i), 32'(o0_valid), 32'd0);
      check($sformatf("mid_post%0d_e", i), 32'(o0_empty), 32'h3);
    end

    // backpressure: sink toggles, source honours pause
    do_reset();
    e0 = '{10'h155, 10'h157, 10'h159, 10'h15B};
    e1 = '{10'h356, 10'h358, 10'h35A, 10'h35C};
    got0 = 0;
    got1 = 0;
    sent = 0;
    cyc  = 0;
    out_ready = 1'b0;
    while ((got0 + got1 < 8) && cyc < 200) begin
      out_ready = ~out_ready;
      if (o0_valid && out_ready) begin
        if (o0_class == 1'b0) begin
          if (got0 < 4) check("bp_c0", 32'(o0_data), 32'(e0[got0]));
          else check("bp_dup0", 32'(got0), 32'd3);
          got0++;
        end else begin
          if (got1 < 4) check("bp_c1", 32'(o0_data), 32'(e1[got1]));
          else check("bp_dup1", 32'(got1), 32'd3);
          got1++;
        end
      end
      if (sent < 8 && !o0_pause) begin
        in_valid = 1'b1;
        in_data  = ((sent % 2) != 0 ? 10'h200 : 10'h000)
                 | (10'h155 + 10'(sent));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_count", 32'(got0 + got1), 32'd8);
    check("bp_err", 32'(o0_err), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_drained", 32'(o0_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
